// File: rtl/histo_readout_if.sv
// rtl/histo_readout_if.sv - histogram read port and output byte stream between histo_readout and its neighbours
interface histo_readout_if #(
  parameter int BIN_W = 10,
  parameter int CNT_W = 24
);
  logic             histo_done;
  logic             hist_rw;
  logic [BIN_W-1:0] hist_bin;
  logic [CNT_W-1:0] hist_data;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  histo_done, hist_data, out_ready,
    output hist_rw, hist_bin, out_data, out_valid
  );

  modport slave (
    output histo_done, hist_data, out_ready,
    input  hist_rw, hist_bin, out_data, out_valid
  );
endinterface

// File: rtl/histo_readout.sv
// rtl/histo_readout.sv - sweeps the histogram on histo_done and streams it as a framed byte stream
// Optional per-frame 32-bit count sum before the footer: define HISTO_READOUT_SUM_EN.
module histo_readout #(
  parameter int NUM_BINS = 1024,
  parameter int BIN_W    = 10,
  parameter int CNT_W    = 24,
  parameter int RD_LAT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  histo_readout_if.master  bus,
  output logic             busy,
  output logic [7:0]       frame_id,
  output logic [7:0]       overrun_cnt
);

  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(RD_LAT);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_WAIT, S_B2, S_B1, S_B0,
`ifdef HISTO_READOUT_SUM_EN
    S_SUM3, S_SUM2, S_SUM1, S_SUM0,
`endif
    S_FOOT
  } state_t;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic             rw_q, rw_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [7:0]       fid_q, fid_d;
  logic [7:0]       ovr_q, ovr_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             cap_q, cap_d;
  logic [CNT_W-1:0] hold_q, hold_d;
`ifdef HISTO_READOUT_SUM_EN
  logic [31:0]      sum_q, sum_d;
`endif

  logic             start;
  logic             xfer;
  logic             cnt_ready;
  logic [CNT_W-1:0] cnt_now;

  always_comb begin
    state_d = state_q;
    done_d  = bus.histo_done;
    rw_d    = rw_q;
    bin_d   = bin_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    fid_d   = fid_q;
    ovr_d   = ovr_q;
    lat_d   = lat_q;
    cap_d   = cap_q;
    hold_d  = hold_q;
`ifdef HISTO_READOUT_SUM_EN
    sum_d   = sum_q;
`endif

    start     = bus.histo_done & ~done_q;
    xfer      = valid_q & bus.out_ready;
    cnt_ready = cap_q | (lat_q == LAT_MAX);
    cnt_now   = cap_q ? hold_q : bus.hist_data;

    // The count is grabbed in whatever state we are in when the latency expires,
    // so a stalled header cannot make bin 0 miss its single valid cycle.
    if (state_q != S_IDLE && !cap_q) begin
      if (lat_q == LAT_MAX) begin
        hold_d = bus.hist_data;
        cap_d  = 1'b1;
      end else begin
        lat_d = lat_q + LAT_W'(1);
      end
    end

    if (start && state_q != S_IDLE && ovr_q != 8'hFF) begin
      ovr_d = ovr_q + 8'd1;
    end

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_HDR0;
        busy_d  = 1'b1;
        rw_d    = 1'b0;
        bin_d   = '0;
        valid_d = 1'b1;
        data_d  = 8'hA5;
        lat_d   = '0;
        cap_d   = 1'b0;
`ifdef HISTO_READOUT_SUM_EN
        sum_d   = '0;
`endif
      end
      S_HDR0: if (xfer) begin
        state_d = S_HDR1;
        data_d  = fid_q;
      end
      S_HDR1: if (xfer) begin
        state_d = S_WAIT;
        valid_d = 1'b0;
      end
      S_WAIT: if (cnt_ready) begin
        state_d = S_B2;
        valid_d = 1'b1;
        data_d  = cnt_now[23:16];
`ifdef HISTO_READOUT_SUM_EN
        sum_d   = sum_q + 32'(cnt_now);
`endif
      end
      S_B2: if (xfer) begin
        state_d = S_B1;
        data_d  = hold_q[15:8];
      end
      S_B1: if (xfer) begin
        state_d = S_B0;
        data_d  = hold_q[7:0];
      end
      S_B0: if (xfer) begin
        if (bin_q == LAST_BIN) begin
          bin_d   = '0;
`ifdef HISTO_READOUT_SUM_EN
          state_d = S_SUM3;
          data_d  = sum_q[31:24];
`else
          state_d = S_FOOT;
          data_d  = 8'h5A;
`endif
        end else begin
          bin_d   = bin_q + BIN_W'(1);
          state_d = S_WAIT;
          valid_d = 1'b0;
          lat_d   = '0;
          cap_d   = 1'b0;
        end
      end
`ifdef HISTO_READOUT_SUM_EN
      S_SUM3: if (xfer) begin
        state_d = S_SUM2;
        data_d  = sum_q[23:16];
      end
      S_SUM2: if (xfer) begin
        state_d = S_SUM1;
        data_d  = sum_q[15:8];
      end
      S_SUM1: if (xfer) begin
        state_d = S_SUM0;
        data_d  = sum_q[7:0];
      end
      S_SUM0: if (xfer) begin
        state_d = S_FOOT;
        data_d  = 8'h5A;
      end
`endif
      S_FOOT: if (xfer) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        rw_d    = 1'b1;
        fid_d   = fid_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      rw_q    <= 1'b1;
      bin_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fid_q   <= '0;
      ovr_q   <= '0;
      lat_q   <= '0;
      cap_q   <= 1'b0;
      hold_q  <= '0;
`ifdef HISTO_READOUT_SUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      rw_q    <= rw_d;
      bin_q   <= bin_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      fid_q   <= fid_d;
      ovr_q   <= ovr_d;
      lat_q   <= lat_d;
      cap_q   <= cap_d;
      hold_q  <= hold_d;
`ifdef HISTO_READOUT_SUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign bus.hist_rw   = rw_q;
  assign bus.hist_bin  = bin_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign busy          = busy_q;
  assign frame_id      = fid_q;
  assign overrun_cnt   = ovr_q;

endmodule
